// File: rtl/ahb3lite_slave_fabric_if.sv
// AHB3-Lite bus bundle between one master, the slave fabric and N_SLAVES slaves.
// HWRITE and HREADY are shared nets: slaves read them directly from the bundle.
interface ahb3lite_slave_fabric_if #(
    parameter int N_SLAVES = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [ADDR_W-1:0]          HADDR;
    logic [1:0]                 HTRANS;
    logic                       HWRITE;
    logic                       HREADY;
    logic                       HRESP;
    logic [DATA_W-1:0]          HRDATA;
    logic [N_SLAVES-1:0]        HSEL_S;
    logic [N_SLAVES-1:0]        HREADYOUT_S;
    logic [N_SLAVES-1:0]        HRESP_S;
    logic [N_SLAVES*DATA_W-1:0] HRDATA_S;

    // Bus master view
    modport master (
        output HADDR, HTRANS, HWRITE,
        input  HREADY, HRESP, HRDATA
    );

    // Fabric view: slave towards the master, decoder/mux towards the slaves
    modport slave (
        input  HADDR, HTRANS, HWRITE, HREADYOUT_S, HRESP_S, HRDATA_S,
        output HREADY, HRESP, HRDATA, HSEL_S
    );
endinterface

// File: rtl/ahb3lite_slave_fabric.sv
// AHB3-Lite address decoder, data-phase response multiplexer and default slave.
// Region index = top REGION_BITS of HADDR; regions >= N_SLAVES are unmapped and
// answered by the built-in default slave with a two-cycle ERROR response.
// Optional macro XFER_CNT_EN adds per-slave transfer counters and an error counter.
module ahb3lite_slave_fabric #(
    parameter int N_SLAVES    = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int REGION_BITS = 4
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ahb3lite_slave_fabric_if.slave bus
`ifdef XFER_CNT_EN
    ,
    output logic [N_SLAVES*16-1:0] xfer_cnt,
    output logic [15:0]            err_cnt
`endif
);

    if ((N_SLAVES < 1) || (N_SLAVES > (1 << REGION_BITS))) begin : g_cfg_err
        $error("ahb3lite_slave_fabric: N_SLAVES must be within 1..2**REGION_BITS");
    end

    localparam logic [REGION_BITS:0] N_SL = (REGION_BITS + 1)'(N_SLAVES);

    typedef enum logic [1:0] {
        DS_OK,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    ds_state_t               state_q, state_d;
    logic [REGION_BITS-1:0]  region;
    logic                    mapped;
    logic [REGION_BITS-1:0]  d_idx_q;
    logic                    d_map_q;
    logic                    d_act_q;
    logic                    hready;
    logic                    hresp;
    logic [DATA_W-1:0]       hrdata;
    logic [N_SLAVES-1:0]     hsel;

    // Low address bits and HWRITE belong to the slaves, not to the decoder
    logic unused_ok;
    assign unused_ok = ^{bus.HADDR, bus.HWRITE};

    // Address decode: region index and one-hot select, for every HTRANS value
    always_comb begin
        region = bus.HADDR[ADDR_W-1 -: REGION_BITS];
        mapped = ({1'b0, region} < N_SL);
        hsel   = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            hsel[i] = (region == REGION_BITS'(i));
        end
    end

    // Data-phase register, advanced only when the bus accepts an address phase
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            d_idx_q <= '0;
            d_map_q <= 1'b1;
            d_act_q <= 1'b0;
        end else if (hready) begin
            d_idx_q <= region;
            d_map_q <= mapped;
            d_act_q <= bus.HTRANS[1];
        end
    end

    // Default-slave state register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= DS_OK;
        end else begin
            state_q <= state_d;
        end
    end

    // Default-slave next state: ERR1 always runs into ERR2; otherwise an accepted
    // active unmapped transfer starts a new error response
    always_comb begin
        state_d = DS_OK;
        if (state_q == DS_ERR1) begin
            state_d = DS_ERR2;
        end else if (hready && bus.HTRANS[1] && !mapped) begin
            state_d = DS_ERR1;
        end
    end

    // Response mux: selected slave when mapped, default slave otherwise
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (d_map_q) begin
            for (int unsigned i = 0; i < N_SLAVES; i++) begin
                if (d_idx_q == REGION_BITS'(i)) begin
                    hready = bus.HREADYOUT_S[i];
                    hresp  = bus.HRESP_S[i];
                    hrdata = bus.HRDATA_S[i*DATA_W +: DATA_W];
                end
            end
        end else begin
            case (state_q)
                DS_ERR1: begin
                    hready = 1'b0;
                    hresp  = 1'b1;
                end
                DS_ERR2: begin
                    hresp  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.HSEL_S = hsel;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = hrdata;

`ifdef XFER_CNT_EN
    logic [15:0] xfer_cnt_q [N_SLAVES];
    logic [15:0] err_cnt_q;
    logic        xfer_hit;
    logic        err_hit;

    // Completion events of the current data phase
    always_comb begin
        xfer_hit = d_map_q && d_act_q && hready && !hresp;
        err_hit  = (!d_map_q && (state_q == DS_ERR2)) ||
                   (d_map_q && d_act_q && hready && hresp);
    end

    // Saturating event counters
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int unsigned i = 0; i < N_SLAVES; i++) begin
                xfer_cnt_q[i] <= '0;
            end
            err_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SLAVES; i++) begin
                if (xfer_hit && (d_idx_q == REGION_BITS'(i)) && (xfer_cnt_q[i] != '1)) begin
                    xfer_cnt_q[i] <= xfer_cnt_q[i] + 16'd1;
                end
            end
            if (err_hit && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // Flatten per-slave counters onto the output bus
    always_comb begin
        xfer_cnt = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            xfer_cnt[i*16 +: 16] = xfer_cnt_q[i];
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb3lite_slave_fabric.sv
// Directed testbench for ahb3lite_slave_fabric (N_SLAVES=2, 32-bit bus).
// Each vector holds one cycle of master/slave stimulus plus optional literal
// expectations; a transaction-level model predicts all outputs every cycle.
module tb_ahb3lite_slave_fabric;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RB = 4;

    localparam logic [1:0] T_I = 2'b00;
    localparam logic [1:0] T_B = 2'b01;
    localparam logic [1:0] T_N = 2'b10;
    localparam logic [1:0] T_S = 2'b11;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ahb3lite_slave_fabric_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef XFER_CNT_EN
    logic [NS*16-1:0] xfer_cnt;
    logic [15:0]      err_cnt;
`endif

    ahb3lite_slave_fabric #(
        .N_SLAVES   (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .REGION_BITS(RB)
    ) dut (
        .HCLK   (clk),
        .HRESETn(rstn),
        .bus    (bus.slave)
`ifdef XFER_CNT_EN
        ,
        .xfer_cnt(xfer_cnt),
        .err_cnt (err_cnt)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic [31:0] addr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [1:0]  rdy;
        logic [1:0]  rsp;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          pin;
        logic        p_rdy;
        logic        p_rsp;
        logic [31:0] p_data;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;
    bit   running = 1'b0;
    int   vidx = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic r, input logic [31:0] a, input logic [1:0] t,
                                input logic w, input logic [1:0] rd, input logic [1:0] rs,
                                input logic [31:0] x0, input logic [31:0] x1, input bit p,
                                input logic pr, input logic ps, input logic [31:0] pd);
        vec_t v;
        v.rst_n = r;  v.addr = a;  v.htrans = t;  v.hwrite = w;
        v.rdy = rd;   v.rsp = rs;  v.d0 = x0;     v.d1 = x1;
        v.pin = p;    v.p_rdy = pr; v.p_rsp = ps; v.p_data = pd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at vector %0d: got 0x%0h, expected 0x%0h", nm, vidx, act, exp);
        end
    endtask

    // Model state: what kind of data phase is in progress and for how long
    bit m_known = 1'b0;
    int m_kind = 0;      // 0 mapped slave, 1 unmapped idle, 2 unmapped active
    int m_slave = 0;
    bit m_active = 1'b0;
    int m_elapsed = 0;
    int m_xfer[NS];
    int m_err = 0;

    // Compare process: predict and check outputs mid-cycle, then advance the model
    always @(negedge clk) begin
        int          region;
        logic [NS-1:0] esel;
        logic        e_rdy;
        logic        e_rsp;
        logic [31:0] e_data;
        if (running) begin
            region = int'(cur.addr[31:28]);
            esel = '0;
            if (region < NS) esel[region] = 1'b1;
            check("hsel", 64'(bus.HSEL_S), 64'(esel));
            e_rdy = 1'b1; e_rsp = 1'b0; e_data = '0;
            if (m_known) begin
                if (m_kind == 0) begin
                    e_rdy  = cur.rdy[m_slave];
                    e_rsp  = cur.rsp[m_slave];
                    e_data = (m_slave == 0) ? cur.d0 : cur.d1;
                end else if (m_kind == 2) begin
                    e_rdy = (m_elapsed == 1);
                    e_rsp = 1'b1;
                end
                check("hready", 64'(bus.HREADY), 64'(e_rdy));
                check("hresp",  64'(bus.HRESP),  64'(e_rsp));
                check("hrdata", 64'(bus.HRDATA), 64'(e_data));
`ifdef XFER_CNT_EN
                check("err_cnt", 64'(err_cnt), 64'(m_err));
                for (int i = 0; i < NS; i++) begin
                    check("xfer_cnt", 64'(xfer_cnt[i*16 +: 16]), 64'(m_xfer[i]));
                end
`endif
            end
            if (cur.pin) begin
                check("pin_hready", 64'(bus.HREADY), 64'(cur.p_rdy));
                check("pin_hresp",  64'(bus.HRESP),  64'(cur.p_rsp));
                check("pin_hrdata", 64'(bus.HRDATA), 64'(cur.p_data));
                if (m_known) begin
                    check("model_hready", 64'(e_rdy), 64'(cur.p_rdy));
                    check("model_hresp",  64'(e_rsp), 64'(cur.p_rsp));
                    check("model_hrdata", 64'(e_data), 64'(cur.p_data));
                end
            end
            if (!cur.rst_n) begin
                m_known = 1'b1; m_kind = 0; m_slave = 0; m_active = 1'b0; m_elapsed = 0;
                m_err = 0;
                for (int i = 0; i < NS; i++) m_xfer[i] = 0;
            end else if (m_known) begin
                if (m_kind == 0 && m_active && e_rdy && !e_rsp && m_xfer[m_slave] < 16'hFFFF)
                    m_xfer[m_slave]++;
                if (((m_kind == 2 && m_elapsed == 1) || (m_kind == 0 && m_active && e_rdy && e_rsp))
                    && m_err < 16'hFFFF)
                    m_err++;
                if (e_rdy) begin
                    m_elapsed = 0;
                    m_active  = cur.htrans[1];
                    if (region < NS) begin
                        m_kind = 0; m_slave = region;
                    end else begin
                        m_kind = cur.htrans[1] ? 2 : 1;
                    end
                end else begin
                    m_elapsed++;
                end
            end
        end
    end

    initial begin
        // reset, then idle data phase to slave 0
        vecs.push_back(mk(0, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 1, 0, 32'h0));
        // single zero-wait write to slave 1
        vecs.push_back(mk(1, 32'h1000_0004, T_N, 1, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h1111_1111, 1, 1, 0, 32'h1111_1111));
        // read from slave 0 with two wait states
        vecs.push_back(mk(1, 32'h0000_0010, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b10, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b10, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'hDEAD_BEEF, 32'h0, 1, 1, 0, 32'hDEAD_BEEF));
        // unmapped NONSEQ: wait+ERROR, then ERROR-complete, data forced to zero
        vecs.push_back(mk(1, 32'h3000_0000, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'hAAAA_5555, 32'h0, 1, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'hAAAA_5555, 32'h0, 1, 1, 1, 32'h0));
        // unmapped IDLE and BUSY: zero-wait OKAY
        vecs.push_back(mk(1, 32'h3000_0000, T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h3000_0000, T_B, 0, 2'b11, 2'b00, 32'hAAAA_5555, 32'h0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'hAAAA_5555, 32'h0, 1, 1, 0, 32'h0));
        // reset, then error followed back-to-back by a slave-0 transfer
        vecs.push_back(mk(0, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h3000_0000, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0000_0020, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h1234_5678, 32'h0, 1, 1, 0, 32'h1234_5678));
        // NONSEQ held during ERR1 is ignored; IDLE in ERR2 cancels it
        vecs.push_back(mk(1, 32'h3000_0000, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h3000_0000, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'h3000_0000, T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h5555_AAAA, 32'h0, 1, 1, 0, 32'h0));
        // two unmapped transfers back to back
        vecs.push_back(mk(1, 32'h3000_0000, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'hF000_0000, T_S, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 1, 0, 32'h0));
        // reset asserted during ERR1
        vecs.push_back(mk(1, 32'h3000_0000, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1, 1, 0, 32'h0));
        // slave 1 returns its own two-cycle ERROR
        vecs.push_back(mk(1, 32'h1000_0000, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b01, 2'b10, 32'h0, 32'h0, 1, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b10, 32'h0, 32'h0, 1, 1, 1, 32'h0));
        // 4-beat INCR burst to slave 1, one wait per beat
        vecs.push_back(mk(1, 32'h1000_0000, T_N, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h1000_0004, T_S, 0, 2'b01, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h1000_0004, T_S, 0, 2'b11, 2'b00, 32'h0, 32'hB0, 1, 1, 0, 32'hB0));
        vecs.push_back(mk(1, 32'h1000_0008, T_S, 0, 2'b01, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h1000_0008, T_S, 0, 2'b11, 2'b00, 32'h0, 32'hB1, 1, 1, 0, 32'hB1));
        vecs.push_back(mk(1, 32'h1000_000C, T_S, 0, 2'b01, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h1000_000C, T_S, 0, 2'b11, 2'b00, 32'h0, 32'hB2, 1, 1, 0, 32'hB2));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b01, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'hB3, 1, 1, 0, 32'hB3));
        vecs.push_back(mk(1, 32'h0,         T_I, 0, 2'b11, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0));

        rstn = 1'b0;
        bus.HADDR = '0; bus.HTRANS = T_I; bus.HWRITE = 1'b0;
        bus.HREADYOUT_S = '1; bus.HRESP_S = '0; bus.HRDATA_S = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            vidx = i;
            cur  = vecs[i];
            rstn = cur.rst_n;
            bus.HADDR = cur.addr;
            bus.HTRANS = cur.htrans;
            bus.HWRITE = cur.hwrite;
            bus.HREADYOUT_S = cur.rdy;
            bus.HRESP_S = cur.rsp;
            bus.HRDATA_S = {cur.d1, cur.d0};
            running = 1'b1;
        end
        @(posedge clk);
        #1;
        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
